// File: rtl/parking_gate_controller_pkg.sv
// Shared constants, FSM state encoding and the free-spot search used by the
// parking gate controller.
package parking_gate_controller_pkg;

    localparam int NUM_SPOTS_DEF   = 8;
    localparam int GATE_CYCLES_DEF = 4;
    localparam int SPOT_W          = 3;
    localparam int COUNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENTRY_OPEN = 2'd1,
        ST_EXIT_OPEN  = 2'd2
    } gate_state_e;

    // Lowest-index free spot; returns 0 when the lot is full (never granted then).
    function automatic logic [SPOT_W-1:0] lowest_free(input logic [NUM_SPOTS_DEF-1:0] occ);
        logic [SPOT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SPOTS_DEF - 1; i >= 0; i--) begin
            if (!occ[i]) idx = SPOT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Request/response bundle between the gate hardware (master) and the controller (slave).
interface parking_gate_controller_if;
    import parking_gate_controller_pkg::*;

    logic                       entry_req;
    logic                       exit_req;
    logic [SPOT_W-1:0]          exit_spot;
    logic                       entry_ack;
    logic [SPOT_W-1:0]          entry_spot;
    logic                       entry_deny;
    logic                       exit_ack;
    logic                       exit_err;
    logic [1:0]                 gate_open;
    logic [NUM_SPOTS_DEF-1:0]   occupancy;
    logic [COUNT_W-1:0]         parked;
    logic [COUNT_W-1:0]         empty;
    logic                       full;

    modport master (
        output entry_req, exit_req, exit_spot,
        input  entry_ack, entry_spot, entry_deny, exit_ack, exit_err,
               gate_open, occupancy, parked, empty, full
    );

    modport slave (
        input  entry_req, exit_req, exit_spot,
        output entry_ack, entry_spot, entry_deny, exit_ack, exit_err,
               gate_open, occupancy, parked, empty, full
    );
endinterface

// File: rtl/parking_gate_controller_spot_popcount.sv
// Population count of an occupancy-sized vector.
module spot_popcount
    import parking_gate_controller_pkg::*;
(
    input  logic [NUM_SPOTS_DEF-1:0] vec_i,
    output logic [COUNT_W-1:0]       count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_SPOTS_DEF; i++) begin
            count_o = count_o + COUNT_W'(vec_i[i]);
        end
    end
endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer for a small parking lot: allocates spots, arbitrates
// simultaneous requests round-robin and times each gate opening.
module parking_gate_controller
    import parking_gate_controller_pkg::*;
#(
    parameter int NUM_SPOTS   = NUM_SPOTS_DEF,
    parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
    input logic                     clk,
    input logic                     rst,
    parking_gate_controller_if.slave bus
);
    localparam logic [3:0] GATE_LEN = 4'(GATE_CYCLES);

    gate_state_e            state_q;
    logic [NUM_SPOTS-1:0]   occ_q;
    logic [SPOT_W-1:0]      entry_spot_q;
    logic [SPOT_W-1:0]      entry_spot_d;
    logic [1:0]             gate_open_q;
    logic [3:0]             timer_q;
    logic                   rr_exit_q;
    logic                   entry_ack_q;
    logic                   exit_ack_q;
    logic                   entry_deny_q;
    logic                   exit_err_q;

    logic full_w;
    logic entry_ok;
    logic exit_ok;
    logic grant_exit;
    logic grant_entry;
    logic deny_w;

    assign full_w       = &occ_q;
    assign entry_spot_d = lowest_free(occ_q);
    assign entry_ok     = bus.entry_req && !full_w;
    assign exit_ok      = bus.exit_req && occ_q[bus.exit_spot];
    // A full lot makes entry unserviceable, so a valid exit always wins then.
    assign grant_exit   = exit_ok && (!entry_ok || rr_exit_q);
    assign grant_entry  = entry_ok && !grant_exit;
    // In IDLE the gate timer doubles as the deny hold-off.
    assign deny_w       = bus.entry_req && !bus.exit_req && (timer_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            occ_q        <= '0;
            entry_spot_q <= '0;
            gate_open_q  <= 2'b00;
            timer_q      <= 4'd0;
            rr_exit_q    <= 1'b1;
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            entry_deny_q <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            entry_ack_q  <= 1'b0;
            exit_ack_q   <= 1'b0;
            entry_deny_q <= 1'b0;
            exit_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_exit) begin
                        occ_q[bus.exit_spot] <= 1'b0;
                        exit_ack_q           <= 1'b1;
                        gate_open_q          <= 2'b10;
                        rr_exit_q            <= 1'b0;
                        timer_q              <= GATE_LEN - 4'd1;
                        state_q              <= ST_EXIT_OPEN;
                    end else if (grant_entry) begin
                        occ_q[entry_spot_d] <= 1'b1;
                        entry_spot_q        <= entry_spot_d;
                        entry_ack_q         <= 1'b1;
                        gate_open_q         <= 2'b01;
                        rr_exit_q           <= 1'b1;
                        timer_q             <= GATE_LEN - 4'd1;
                        state_q             <= ST_ENTRY_OPEN;
                    end else begin
                        if (bus.exit_req) begin
                            exit_err_q <= 1'b1;
                        end else if (deny_w) begin
                            entry_deny_q <= 1'b1;
                        end
                        if (!bus.exit_req && deny_w) begin
                            timer_q <= GATE_LEN;
                        end else if (timer_q != 4'd0) begin
                            timer_q <= timer_q - 4'd1;
                        end
                    end
                end
                ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
                    if (timer_q == 4'd0) begin
                        gate_open_q <= 2'b00;
                        state_q     <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - 4'd1;
                    end
                end
                default: begin
                    gate_open_q <= 2'b00;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.entry_ack  = entry_ack_q;
    assign bus.exit_ack   = exit_ack_q;
    assign bus.entry_deny = entry_deny_q;
    assign bus.exit_err   = exit_err_q;
    assign bus.entry_spot = entry_spot_q;
    assign bus.gate_open  = gate_open_q;
    assign bus.occupancy  = occ_q;
    assign bus.full       = full_w;

    spot_popcount u_parked (
        .vec_i   (occ_q),
        .count_o (bus.parked)
    );

    spot_popcount u_empty (
        .vec_i   (~occ_q),
        .count_o (bus.empty)
    );
endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter NUM_SPOTS, default 8, number of parking spots; this is the only supported value in this revision.
REQ-002 Parameter GATE_CYCLES, default 4, clock cycles a gate stays open after a grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 entry_req  input  1  level; a car is waiting at the entry gate.
REQ-006 exit_req  input  1  level; a car is waiting at the exit gate.
REQ-007 exit_spot  input  3  index of the spot being vacated; valid while exit_req=1.
REQ-008 entry_ack  output  1  one-cycle pulse; entry granted.
REQ-009 entry_spot  output  3  assigned spot; valid in the entry_ack cycle, otherwise holds its last value.
REQ-010 entry_deny  output  1  one-cycle pulse; entry refused because the lot is full.
REQ-011 exit_ack  output  1  one-cycle pulse; exit granted.
REQ-012 exit_err  output  1  one-cycle pulse; exit_spot was not occupied.
REQ-013 gate_open  output  2  bit0 = entry gate open, bit1 = exit gate open.
REQ-014 occupancy  output  8  bit i = 1 means spot i is occupied.
REQ-015 parked / empty  output  4 each  population count of occupancy and its complement.
REQ-016 full  output  1  occupancy == 8'hFF.

Function
REQ-017 FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN; only IDLE samples requests.
REQ-018 IDLE with exactly one serviceable request moves to the matching *_OPEN state; the ack pulse is registered and is high in the first *_OPEN cycle, so latency from request to ack is 1 cycle.
REQ-019 Entry grant: entry_spot = lowest-index 0 bit of occupancy; that bit is set in the same edge that raises entry_ack.
REQ-020 Exit grant: occupancy[exit_spot] is cleared in the same edge that raises exit_ack.
REQ-021 *_OPEN holds the matching gate_open bit high for exactly GATE_CYCLES cycles, then returns to IDLE; requests are ignored while a gate is open.
REQ-022 Simultaneous entry_req and exit_req in IDLE: round-robin arbitration; the requester not served last wins. After reset, exit has priority.
REQ-023 entry_req while full with no exit_req: entry_deny pulses for 1 cycle; the FSM stays in IDLE, and occupancy is unchanged. The deny re-pulses every GATE_CYCLES+1 cycles while the request persists.
REQ-024 entry_req while full with exit_req pending: the exit is always served first, overriding round-robin; entry_deny is not asserted.
REQ-025 exit_req with occupancy[exit_spot]=0: exit_err pulses for 1 cycle, there is no ack, occupancy is unchanged, and the FSM stays in IDLE.
REQ-026 A request still high when the FSM returns to IDLE is treated as a new request; each gate drops its request after its ack.
REQ-027 parked + empty = 8 at all times; full, parked and empty are combinational from registered occupancy.
REQ-028 At most one of entry_ack, exit_ack, entry_deny or exit_err is high in any cycle.

Reset
REQ-029 rst=1 at a clock edge forces: state IDLE, occupancy 8'h00, all pulses 0, gate_open 2'b00, entry_spot 3'd0, round-robin pointer to exit-priority, gate timer 0.
REQ-030 rst=1 during ENTRY_OPEN or EXIT_OPEN aborts the operation immediately and discards the grant, with no partial occupancy retained.

Structure
REQ-031 A shared package holds NUM_SPOTS, GATE_CYCLES default, the FSM state encoding (2-bit) and the spot index width.
REQ-032 One sub-module, spot_popcount, is natural: 8-bit vector in, 4-bit count out; it is instantiated twice, for parked and empty.

Verification
REQ-033 Reset, then entry_req held until ack -> entry_ack at cycle 1, entry_spot=0, occupancy=8'h01, gate_open=01 for 4 cycles, parked=1, empty=7.
REQ-034 occupancy=8'hFB (spot 2 free), entry_req -> entry_spot=2, occupancy=8'hFF, full=1, parked=8, empty=0.
REQ-035 full lot, entry_req only -> entry_deny pulses, occupancy stays 8'hFF; then add exit_req with exit_spot=5 -> exit_ack, occupancy=8'hDF, and the next IDLE grants entry with entry_spot=5.
REQ-036 Both requests together in IDLE three times after reset -> service order exit, entry, exit.
REQ-037 occupancy=8'h01, exit_req with exit_spot=3 -> exit_err pulse, no exit_ack, occupancy=8'h01.
REQ-038 rst asserted in the 2nd cycle of ENTRY_OPEN -> next cycle state IDLE, occupancy=8'h00, gate_open=00.
